imem_responder: RTL
===================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256; instruction words stored, power of two.
REQ-002 SHALL have parameter LATENCY, default 2; cycles from request accept to rsp_valid, legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  core presents fetch request.
REQ-006 SHALL have port req_ready  output  1  responder accepts request.
REQ-007 SHALL have port req_addr  input  32  byte address of fetch (the core's pc).
REQ-008 SHALL have port rsp_valid  output  1  instruction available.
REQ-009 SHALL have port rsp_ready  input  1  core consumes response.
REQ-010 SHALL have port rsp_inst  output  32  fetched instruction word.
REQ-011 SHALL have port rsp_err  output  1  access fault on this response.
REQ-012 SHALL have ports load_en input 1, load_addr input 32, load_data input 32: program-load write port, word written at load_addr[31:2].

Function
REQ-013 SHALL implement states IDLE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-014 Accept occurs on a rising edge with req_valid && req_ready; SHALL latch req_addr and go to WAIT (LATENCY>1) or RESP (LATENCY==1).
REQ-015 WAIT SHALL count down a 4-bit counter loaded with LATENCY-1; enter RESP on the edge where counter reaches 0, so rsp_valid rises exactly LATENCY edges after the accepting edge.
REQ-016 rsp_inst SHALL be the array word at latched addr[31:2], sampled on the edge entering RESP, held stable while rsp_valid && !rsp_ready.
REQ-017 RESP -> IDLE on the edge with rsp_ready=1; no new request accepted in that same edge (one bubble cycle minimum between responses).
REQ-018 Word index >= DEPTH_WORDS SHALL give rsp_err=1 and rsp_inst=32'h00000013 (NOP), same latency as a normal fetch.
REQ-019 rsp_err SHALL be 0 in any state other than RESP.
REQ-020 Load write SHALL occur on any rising edge with load_en=1 regardless of state; out-of-range load_addr silently ignored.
REQ-021 Load and RESP-entry to the same word on the same edge: rsp_inst SHALL return the old (pre-write) data.
REQ-022 req_addr SHALL be ignored outside IDLE; at most one request outstanding.

Reset
REQ-023 reset SHALL force state IDLE, counter 0, rsp_valid=0, rsp_err=0, rsp_inst=32'h00000013, req_ready=1 immediately (asynchronously).
REQ-024 Reset mid-WAIT or mid-RESP SHALL drop the outstanding request with no response after reset deassertion.
REQ-025 Array contents SHALL NOT be reset.

Configuration
REQ-026 Macro IMEM_MISALIGN_TRAP_EN defined: req_addr[1:0]!=0 SHALL give rsp_err=1, rsp_inst=NOP, normal latency.
REQ-027 Macro undefined: req_addr[1:0] SHALL be ignored, misaligned fetches return the enclosing word with rsp_err=0.

Structure
REQ-028 Package imem_pkg SHALL hold XLEN=32, NOP_INST=32'h00000013, and the IDLE/WAIT/RESP state encoding.
REQ-029 Storage SHALL be a sub-module imem_array (synchronous write port, synchronous read port); FSM and handshake stay in imem_responder.

Verification
REQ-030 Load 0x00500093 at 0x0; request addr 0x0 with LATENCY=2, rsp_ready=1 -> rsp_valid high 2 edges after accept, rsp_inst=0x00500093, rsp_err=0.
REQ-031 Request 0x4, hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_inst stable all 5 cycles, req_ready=0; release -> IDLE next edge.
REQ-032 DEPTH_WORDS=256, request 0x400 -> rsp_err=1, rsp_inst=0x00000013.
REQ-033 IMEM_MISALIGN_TRAP_EN defined, request 0x6 -> rsp_err=1; undefined -> word at 0x4, rsp_err=0.
REQ-034 Assert reset during WAIT -> rsp_valid=0 same cycle, no response after release, req_ready=1.
REQ-035 load_en writing 0xDEADBEEF at 0x8 on the RESP-entry edge of a fetch to 0x8 -> rsp_inst=old word; next fetch to 0x8 returns 0xDEADBEEF.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: data width,
// the NOP returned on faulting fetches, and the responder state encoding.
package imem_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port for program loading and
// one synchronous read port for fetches. Contents are never reset. A read
// and a write to the same word on the same edge return the old word.
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_index,
  input  logic [XLEN-1:0] wr_data,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_index,
  output logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  // Program-load write, accepted whenever the loader asserts it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_index] <= wr_data;
    end
  end

  // Fetch read, captured only when the responder enters RESP so the word stays put.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_index];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: accepts one fetch at a time, waits a fixed
// LATENCY, then presents the word until the core takes it.
// Optional build macro IMEM_MISALIGN_TRAP_EN: when defined, fetches whose
// req_addr[1:0] is nonzero fault (rsp_err=1, NOP); otherwise those bits are
// ignored and the enclosing word is returned.
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_inst,
  output logic            rsp_err,
  input  logic            load_en,
  input  logic [XLEN-1:0] load_addr,
  input  logic [XLEN-1:0] load_data
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t          state;
  state_t          state_next;
  logic [3:0]      count;
  logic [3:0]      count_next;
  logic [AW-1:0]   word_q;
  logic            err_q;
  logic            accept;
  logic            rd_en;
  logic [AW-1:0]   rd_index;
  logic [XLEN-1:0] rd_data;
  logic            req_err;
  logic            wr_en;

  // A word index with any bit set above the array size is outside the memory.
`ifdef IMEM_MISALIGN_TRAP_EN
  assign req_err = (|req_addr[XLEN-1:AW+2]) | (|req_addr[1:0]);
`else
  logic unused_req_bits;
  assign unused_req_bits = ^req_addr[1:0];
  assign req_err = |req_addr[XLEN-1:AW+2];
`endif

  logic unused_load_bits;
  assign unused_load_bits = ^load_addr[1:0];

  assign wr_en = load_en && !(|load_addr[XLEN-1:AW+2]);

  // With LATENCY==1 the read happens on the accepting edge, so it must use the live address.
  assign rd_index = (state == IDLE) ? req_addr[AW+1:2] : word_q;

  // Next-state and read-strobe logic for the IDLE/WAIT/RESP handshake.
  always_comb begin
    state_next = state;
    count_next = count;
    accept     = 1'b0;
    rd_en      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_next = RESP;
            rd_en      = 1'b1;
          end else begin
            state_next = WAIT;
            count_next = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        count_next = count - 4'd1;
        if (count == 4'd1) begin
          state_next = RESP;
          rd_en      = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, countdown and the latched request; reset drops any outstanding fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= 4'd0;
      word_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (accept) begin
        word_q <= req_addr[AW+1:2];
        err_q  <= req_err;
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_inst  = (rsp_valid && !err_q) ? rd_data : NOP_INST;

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_index(load_addr[AW+1:2]),
    .wr_data (load_data),
    .rd_en   (rd_en),
    .rd_index(rd_index),
    .rd_data (rd_data)
  );

endmodule
